seq_div16x8: RTL

- Sequential restoring divider: 16-bit dividend ÷ 8-bit divisor, producing a 16-bit quotient and an 8-bit remainder.
- It is the inverse path of the 8x8 multiply / add datapath. It recovers an operand from a 16-bit product or accumulated sum.
- Resolves one quotient bit per clock, behind a start/busy/done handshake.

---
 rtl/seq_div16x8_pkg.sv | 18 +
 rtl/seq_div16x8_div_step.sv | 32 +++
 rtl/seq_div16x8.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/seq_div16x8_pkg.sv
// Shared types and constants for the sequential 16/8 restoring divider.
`timescale 1ns/1ps
package seq_div_pkg;

   localparam int DVD_W = 16;
   localparam int DVS_W = 8;
   localparam int CNT_W = $clog2(DVD_W);

   // Quotient reported when the divisor is zero.
   localparam logic [DVD_W-1:0] DZ_QUOTIENT = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/seq_div16x8_div_step.sv
// One restoring-division iteration: shift {partial_rem, shift_reg} left,
// try to subtract the divisor, keep the difference when it does not underflow.
`timescale 1ns/1ps
module div_step #(
   parameter int DVD_W = seq_div_pkg::DVD_W,
   parameter int DVS_W = seq_div_pkg::DVS_W
) (
   input  logic [DVS_W:0]   partial_rem,
   input  logic [DVD_W-1:0] shift_reg,
   input  logic [DVS_W-1:0] divisor,
   output logic [DVS_W:0]   partial_rem_next,
   output logic [DVD_W-1:0] shift_reg_next
);

   // One extra bit above the partial remainder keeps the compare exact even
   // if the top bit were ever set; in normal operation it is always zero.
   logic [DVS_W+1:0] shifted;
   logic             fits;

   // Shift, trial-subtract and select the restored or reduced remainder.
   always_comb begin
      shifted = {partial_rem, shift_reg[DVD_W-1]};
      fits    = (shifted >= {2'b00, divisor});
      if (fits) begin
         partial_rem_next = (DVS_W+1)'(shifted - {2'b00, divisor});
      end else begin
         partial_rem_next = shifted[DVS_W:0];
      end
      shift_reg_next = {shift_reg[DVD_W-2:0], fits};
   end

endmodule

// File: rtl/seq_div16x8.sv
// Sequential restoring divider: DVD_W-bit dividend / DVS_W-bit divisor,
// one quotient bit per clock behind a start/busy/done handshake.
//
//   state | meaning
//   IDLE  | waiting for start; results from the last divide are held
//   RUN   | one restoring step per cycle, counter counts down to zero
//   DONE  | results just updated, done pulses for this single cycle
`timescale 1ns/1ps
module seq_div16x8 #(
   parameter int DVD_W = seq_div_pkg::DVD_W,
   parameter int DVS_W = seq_div_pkg::DVS_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DVD_W-1:0] dividend,
   input  logic [DVS_W-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [DVD_W-1:0] quotient,
   output logic [DVS_W-1:0] remainder,
   output logic             div_by_zero
);

   import seq_div_pkg::*;

   localparam int CNT_W = $clog2(DVD_W);

   div_state_e       state;
   div_state_e       state_next;

   logic [CNT_W-1:0] cnt;
   logic [DVS_W:0]   partial_rem;
   logic [DVD_W-1:0] shift_reg;
   logic [DVS_W-1:0] divisor_r;

   logic [DVD_W-1:0] quotient_r;
   logic [DVS_W-1:0] remainder_r;
   logic             div_by_zero_r;

   logic [DVS_W:0]   partial_rem_next;
   logic [DVD_W-1:0] shift_reg_next;

   logic             accept;
   logic             last_step;
   logic             divisor_zero;

   assign accept       = (state == IDLE) && start;
   assign last_step    = (state == RUN) && (cnt == '0);
   assign divisor_zero = (divisor == '0);

   div_step #(
      .DVD_W (DVD_W),
      .DVS_W (DVS_W)
   ) u_step (
      .partial_rem      (partial_rem),
      .shift_reg        (shift_reg),
      .divisor          (divisor_r),
      .partial_rem_next (partial_rem_next),
      .shift_reg_next   (shift_reg_next)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode; a zero divisor skips the iterations entirely.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = divisor_zero ? DONE : RUN;
            end
         end
         RUN: begin
            if (cnt == '0) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs are pure functions of the state.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         RUN:  busy = 1'b1;
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   // Working registers: operand latch on accept, one step per RUN cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         partial_rem <= '0;
         shift_reg   <= '0;
         divisor_r   <= '0;
      end else if (accept) begin
         cnt         <= CNT_W'(DVD_W - 1);
         partial_rem <= '0;
         shift_reg   <= dividend;
         divisor_r   <= divisor;
      end else if (state == RUN) begin
         partial_rem <= partial_rem_next;
         shift_reg   <= shift_reg_next;
         if (cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   // Result registers: written only when entering DONE, so RUN never
   // exposes intermediate values.
   always_ff @(posedge clk) begin
      if (rst) begin
         quotient_r    <= '0;
         remainder_r   <= '0;
         div_by_zero_r <= 1'b0;
      end else if (accept) begin
         div_by_zero_r <= divisor_zero;
         if (divisor_zero) begin
            quotient_r  <= DZ_QUOTIENT;
            remainder_r <= dividend[DVS_W-1:0];
         end
      end else if (last_step) begin
         quotient_r  <= shift_reg_next;
         remainder_r <= partial_rem_next[DVS_W-1:0];
      end
   end

   assign quotient    = quotient_r;
   assign remainder   = remainder_r;
   assign div_by_zero = div_by_zero_r;

endmodule
